// File: rtl/load_store_ctrl.sv
// Requester-side load/store controller for the word-indexed data RAM.
// Splits doublewords into two word accesses and formats load results.
module load_store_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              Start,
  input  logic              IsStore,
  input  logic [1:0]        Size,
  input  logic              SignExt,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [63:0]       StoreData,
  output logic              Busy,
  output logic              Done,
  output logic [63:0]       LoadData,
  output logic              MemEnable,
  output logic              MemReadWrite,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [31:0]       MemDataIn,
  output logic [1:0]        MemDataSize,
  input  logic [31:0]       MemDataOut
);

  localparam logic [3:0]        LAT_LAST = 4'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [63:0] format_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        sign_ext);
    logic [63:0] result;
    case (size)
      2'b00:   result = {{56{sign_ext & word[7]}}, word[7:0]};
      2'b01:   result = {{48{sign_ext & word[15]}}, word[15:0]};
      default: result = {{32{sign_ext & word[31]}}, word};
    endcase
    return result;
  endfunction

  state_t             state_r, state_s;
  logic [3:0]         cnt_r, cnt_s;
  logic               last_s, capture_s;
  logic               is_store_r, sign_ext_r;
  logic [1:0]         size_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [63:0]        store_data_r;
  logic [31:0]        first_word_r, first_word_s;
  logic [63:0]        load_data_s;
  logic               req_store_s;
  logic [1:0]         req_size_s;
  logic [ADDR_W-1:0]  req_addr_s;
  logic [63:0]        req_data_s;
  logic               en_s, rw_s;
  logic [ADDR_W-1:0]  addr_s;
  logic [31:0]        din_s;
  logic [1:0]         dsize_s;

  // Next state and per-access wait counter
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    last_s    = (cnt_r == LAT_LAST);
    case (state_r)
      IDLE: begin
        if (Start) begin
          state_s   = ACC0;
          cnt_s     = 4'd0;
          capture_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ACC0: begin
        if (last_s) begin
          cnt_s   = 4'd0;
          state_s = (size_r == 2'b11) ? ACC1 : DONE;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      ACC1: begin
        if (last_s) begin
          cnt_s   = 4'd0;
          state_s = DONE;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      DONE:    state_s = IDLE;
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // RAM pins for the upcoming cycle; the request is taken straight from the inputs on capture
  always_comb begin
    req_store_s = capture_s ? IsStore   : is_store_r;
    req_size_s  = capture_s ? Size      : size_r;
    req_addr_s  = capture_s ? Addr      : addr_r;
    req_data_s  = capture_s ? StoreData : store_data_r;
    en_s    = 1'b0;
    rw_s    = 1'b0;
    addr_s  = MemAddress;
    din_s   = MemDataIn;
    dsize_s = MemDataSize;
    case (state_s)
      ACC0: begin
        en_s    = 1'b1;
        rw_s    = req_store_s;
        addr_s  = req_addr_s;
        dsize_s = (req_size_s == 2'b11) ? 2'b10 : req_size_s;
        case (req_size_s)
          2'b00:   din_s = {24'd0, req_data_s[7:0]};
          2'b01:   din_s = {16'd0, req_data_s[15:0]};
          default: din_s = req_data_s[31:0];
        endcase
      end
      ACC1: begin
        en_s    = 1'b1;
        rw_s    = req_store_s;
        addr_s  = req_addr_s + ADDR_ONE;
        din_s   = req_data_s[63:32];
        dsize_s = 2'b10;
      end
      default: begin
        en_s = 1'b0;
        rw_s = 1'b0;
      end
    endcase
  end

  // Read data is taken at the edge closing the last cycle of each load access
  always_comb begin
    load_data_s  = LoadData;
    first_word_s = first_word_r;
    if (state_r == ACC0 && last_s && !is_store_r) begin
      if (size_r == 2'b11) begin
        first_word_s = MemDataOut;
      end else begin
        load_data_s = format_load(MemDataOut, size_r, sign_ext_r);
      end
    end else if (state_r == ACC1 && last_s && !is_store_r) begin
      load_data_s = {MemDataOut, first_word_r};
    end else begin
      load_data_s = LoadData;
    end
  end

  // State, request latch and registered outputs
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_r      <= IDLE;
      cnt_r        <= 4'd0;
      is_store_r   <= 1'b0;
      size_r       <= 2'b00;
      sign_ext_r   <= 1'b0;
      addr_r       <= '0;
      store_data_r <= 64'd0;
      first_word_r <= 32'd0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      LoadData     <= 64'd0;
      MemEnable    <= 1'b0;
      MemReadWrite <= 1'b0;
      MemAddress   <= '0;
      MemDataIn    <= 32'd0;
      MemDataSize  <= 2'b00;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      if (capture_s) begin
        is_store_r   <= IsStore;
        size_r       <= Size;
        sign_ext_r   <= SignExt;
        addr_r       <= Addr;
        store_data_r <= StoreData;
      end
      first_word_r <= first_word_s;
      Busy         <= (state_s != IDLE);
      Done         <= (state_s == DONE);
      LoadData     <= load_data_s;
      MemEnable    <= en_s;
      MemReadWrite <= rw_s;
      MemAddress   <= addr_s;
      MemDataIn    <= din_s;
      MemDataSize  <= dsize_s;
    end
  end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Bench for load_store_ctrl: two instances (MEM_LAT 1 and 3) share stimulus,
// each attached to its own behavioural RAM; results checked against a transaction-level model.
module tb_load_store_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ram_clear = 1'b1;
  logic        start = 1'b0, is_store = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [7:0]  addr = 8'd0;
  logic [63:0] store_data = 64'd0;

  logic [1:0]        busy, done, en, rw;
  logic [1:0][63:0]  ld;
  logic [1:0][7:0]   maddr;
  logic [1:0][31:0]  mdin, mdout;
  logic [1:0][1:0]   mdsz;

  logic [31:0] ram [2][256];
  logic [31:0] ref_mem [256];
  logic [63:0] ref_ld = 64'd0;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  load_store_ctrl #(.ADDR_W(8), .MEM_LAT(1)) u_dut_l1 (
    .Clk(clk), .ResetN(rst_n), .Start(start), .IsStore(is_store), .Size(size),
    .SignExt(sign_ext), .Addr(addr), .StoreData(store_data), .Busy(busy[0]),
    .Done(done[0]), .LoadData(ld[0]), .MemEnable(en[0]), .MemReadWrite(rw[0]),
    .MemAddress(maddr[0]), .MemDataIn(mdin[0]), .MemDataSize(mdsz[0]),
    .MemDataOut(mdout[0]));

  load_store_ctrl #(.ADDR_W(8), .MEM_LAT(3)) u_dut_l3 (
    .Clk(clk), .ResetN(rst_n), .Start(start), .IsStore(is_store), .Size(size),
    .SignExt(sign_ext), .Addr(addr), .StoreData(store_data), .Busy(busy[1]),
    .Done(done[1]), .LoadData(ld[1]), .MemEnable(en[1]), .MemReadWrite(rw[1]),
    .MemAddress(maddr[1]), .MemDataIn(mdin[1]), .MemDataSize(mdsz[1]),
    .MemDataOut(mdout[1]));

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [1:0] sz);
    case (sz)
      2'b00:   return {old[31:8], din[7:0]};
      2'b01:   return {old[31:16], din[15:0]};
      default: return din;
    endcase
  endfunction

  // Behavioural RAMs: combinational read, write on every enabled write edge
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int k = 0; k < 256; k++) begin
        ram[0][k] <= 32'd0;
        ram[1][k] <= 32'd0;
      end
    end else begin
      if (en[0] && rw[0]) ram[0][maddr[0]] <= merge(ram[0][maddr[0]], mdin[0], mdsz[0]);
      if (en[1] && rw[1]) ram[1][maddr[1]] <= merge(ram[1][maddr[1]], mdin[1], mdsz[1]);
    end
  end
  assign mdout[0] = ram[0][maddr[0]];
  assign mdout[1] = ram[1][maddr[1]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One request applied to both instances; 12 cycles observed per request
  task automatic run(input bit st, input logic [1:0] sz, input bit sx, input logic [7:0] a,
                     input logic [63:0] d, input bit hold, input bit use_c,
                     input logic [63:0] cexp);
    int done_cyc [2];
    int n_done [2];
    int n_en [2];
    bit busy_bad [2];
    bit pin_bad [2];
    logic [7:0]  a1;
    logic [63:0] exp_ld, raw;
    logic [31:0] w, din0;
    logic [1:0]  dsz0;
    int l;
    a1 = a + 8'd1;
    w  = ref_mem[a];
    case (sz)
      2'b00: begin raw = {56'd0, w[7:0]};  if (sx && raw >= 64'd128)        raw = raw - 64'd256; end
      2'b01: begin raw = {48'd0, w[15:0]}; if (sx && raw >= 64'd32768)      raw = raw - 64'd65536; end
      2'b10: begin raw = {32'd0, w};       if (sx && raw >= 64'h8000_0000)  raw = raw - 64'h1_0000_0000; end
      default: raw = {ref_mem[a1], ref_mem[a]};
    endcase
    exp_ld = st ? ref_ld : (use_c ? cexp : raw);
    din0 = (sz == 2'b00) ? {24'd0, d[7:0]} : (sz == 2'b01) ? {16'd0, d[15:0]} : d[31:0];
    dsz0 = (sz == 2'b11) ? 2'b10 : sz;
    for (int i = 0; i < 2; i++) begin
      done_cyc[i] = 0; n_done[i] = 0; n_en[i] = 0; busy_bad[i] = 1'b0; pin_bad[i] = 1'b0;
    end
    @(negedge clk);
    is_store = st; size = sz; sign_ext = sx; addr = a; store_data = d; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        l = (i == 0) ? 1 : 3;
        if (done_cyc[i] == 0 && !busy[i]) busy_bad[i] = 1'b1;
        if (done[i]) begin
          n_done[i]++;
          if (done_cyc[i] == 0) done_cyc[i] = c;
        end
        if (en[i]) begin
          n_en[i]++;
          if (rw[i] !== st) pin_bad[i] = 1'b1;
          if (c <= l) begin
            if (maddr[i] !== a || mdin[i] !== din0 || mdsz[i] !== dsz0) pin_bad[i] = 1'b1;
          end else begin
            if (maddr[i] !== a1 || mdin[i] !== d[63:32] || mdsz[i] !== 2'b10) pin_bad[i] = 1'b1;
          end
        end else if (rw[i]) begin
          pin_bad[i] = 1'b1;
        end
      end
      if (!hold || done[0]) start = 1'b0;
    end
    start = 1'b0;
    if (st) begin
      ref_mem[a] = merge(ref_mem[a], din0, dsz0);
      if (sz == 2'b11) ref_mem[a1] = d[63:32];
    end else begin
      ref_ld = raw;
    end
    for (int i = 0; i < 2; i++) begin
      l = (i == 0) ? 1 : 3;
      chk($sformatf("lat%0d done cycle", l), 64'(done_cyc[i]), 64'((sz == 2'b11) ? 2*l+1 : l+1));
      chk($sformatf("lat%0d done pulses", l), 64'(n_done[i]), 64'd1);
      chk($sformatf("lat%0d enable cycles", l), 64'(n_en[i]), 64'((sz == 2'b11) ? 2*l : l));
      chk($sformatf("lat%0d busy gap", l), 64'(busy_bad[i]), 64'd0);
      chk($sformatf("lat%0d ram pins", l), 64'(pin_bad[i]), 64'd0);
      chk($sformatf("lat%0d LoadData", l), ld[i], exp_ld);
      if (st) begin
        chk($sformatf("lat%0d ram[%h]", l, a), 64'(ram[i][a]), 64'(ref_mem[a]));
        if (sz == 2'b11) chk($sformatf("lat%0d ram[%h]", l, a1), 64'(ram[i][a1]), 64'(ref_mem[a1]));
      end
    end
  endtask

  typedef struct {
    bit          st;
    logic [1:0]  sz;
    bit          sx;
    logic [7:0]  a;
    logic [63:0] d;
    bit          hold;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int nd;
    tbl[0]  = '{1'b1, 2'b10, 1'b0, 8'h10, 64'h00000000_DEADBEEF, 1'b0, 64'h0};
    tbl[1]  = '{1'b0, 2'b10, 1'b0, 8'h10, 64'h0, 1'b0, 64'h00000000_DEADBEEF};
    tbl[2]  = '{1'b1, 2'b10, 1'b0, 8'h20, 64'h00000000_000000F0, 1'b0, 64'h0};
    tbl[3]  = '{1'b0, 2'b00, 1'b1, 8'h20, 64'h0, 1'b0, 64'hFFFFFFFF_FFFFFFF0};
    tbl[4]  = '{1'b0, 2'b00, 1'b0, 8'h20, 64'h0, 1'b0, 64'h00000000_000000F0};
    tbl[5]  = '{1'b1, 2'b11, 1'b0, 8'hFF, 64'h11223344_55667788, 1'b0, 64'h0};
    tbl[6]  = '{1'b0, 2'b11, 1'b1, 8'hFF, 64'h0, 1'b0, 64'h11223344_55667788};
    tbl[7]  = '{1'b1, 2'b10, 1'b0, 8'h30, 64'h00000000_00008001, 1'b0, 64'h0};
    tbl[8]  = '{1'b0, 2'b01, 1'b1, 8'h30, 64'h0, 1'b0, 64'hFFFFFFFF_FFFF8001};
    tbl[9]  = '{1'b0, 2'b11, 1'b0, 8'hFF, 64'h0, 1'b1, 64'h11223344_55667788};
    tbl[10] = '{1'b1, 2'b00, 1'b0, 8'h30, 64'h12345678_9ABCDEAB, 1'b0, 64'h0};
    tbl[11] = '{1'b0, 2'b10, 1'b0, 8'h30, 64'h0, 1'b0, 64'h00000000_000080AB};
    tbl[12] = '{1'b1, 2'b10, 1'b0, 8'h31, 64'h00000000_80000000, 1'b0, 64'h0};
    tbl[13] = '{1'b0, 2'b10, 1'b1, 8'h31, 64'h0, 1'b0, 64'hFFFFFFFF_80000000};
    for (int k = 0; k < 256; k++) ref_mem[k] = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset dut%0d ctrl", i), {60'd0, busy[i], done[i], en[i], rw[i]}, 64'd0);
      chk($sformatf("reset dut%0d pins", i), {22'd0, mdsz[i], maddr[i], mdin[i]}, 64'd0);
      chk($sformatf("reset dut%0d LoadData", i), ld[i], 64'd0);
    end
    @(negedge clk);
    ram_clear = 1'b0;
    rst_n = 1'b1;

    for (int v = 0; v < 14; v++)
      run(tbl[v].st, tbl[v].sz, tbl[v].sx, tbl[v].a, tbl[v].d, tbl[v].hold, !tbl[v].st, tbl[v].exp);

    for (int r = 0; r < 40; r++) begin
      logic [7:0] ra;
      ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(248, 255));
      run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra,
          {$urandom, $urandom}, ($urandom_range(0, 7) == 0), 1'b0, 64'd0);
    end

    // Reset during the second word of a doubleword store
    run(1'b1, 2'b10, 1'b0, 8'h40, 64'hAAAAAAAA, 1'b0, 1'b0, 64'd0);
    run(1'b1, 2'b10, 1'b0, 8'h41, 64'hAAAAAAAA, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    is_store = 1'b1; size = 2'b11; addr = 8'h40; store_data = 64'h12345678_9ABCDEF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort lat1 in second access", {62'd0, en[0], maddr[0] == 8'h41}, 64'd3);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("abort dut%0d ctrl", i), {60'd0, busy[i], done[i], en[i], rw[i]}, 64'd0);
      chk($sformatf("abort dut%0d LoadData", i), ld[i], 64'd0);
    end
    ref_ld = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done[0] || done[1] || en[0] || en[1]) nd++;
    end
    chk("abort no activity after reset", 64'(nd), 64'd0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("abort dut%0d first word", i), 64'(ram[i][8'h40]), 64'h9ABCDEF0);
      chk($sformatf("abort dut%0d second word", i), 64'(ram[i][8'h41]), 64'hAAAAAAAA);
    end
    ref_mem[8'h40] = 32'h9ABCDEF0;
    run(1'b0, 2'b11, 1'b0, 8'h40, 64'd0, 1'b0, 1'b1, 64'hAAAAAAAA_9ABCDEF0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
